// File: rtl/apb_pkg.sv
// Shared types for the APB4 protocol checker: phase tracking states, check codes
// and the priority helper that picks the reported code when several checks fire.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  typedef enum logic [2:0] {
    CHK_SEL_MULTI = 3'd0,
    CHK_NO_ACCESS = 3'd1,
    CHK_EN_NO_SEL = 3'd2,
    CHK_UNSTABLE  = 3'd3,
    CHK_MISS_ERR  = 3'd4,
    CHK_FALSE_ERR = 3'd5,
    CHK_TIMEOUT   = 3'd6,
    CHK_READ_STRB = 3'd7
  } apb_chk_e;

  localparam int NUM_CHK = 8;

  // Lowest-numbered code wins when several checks fire on the same edge.
  function automatic logic [2:0] lowest_code(input logic [NUM_CHK-1:0] hits);
    lowest_code = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (hits[i]) lowest_code = 3'(i);
    end
  endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// APB4 bus bundle for one segment with NUM_SEL slave selects; the checker
// attaches through the passive monitor view.
interface apb_protocol_checker_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_SEL    = 4
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [NUM_SEL-1:0]    psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

  modport monitor (
    input paddr, psel, penable, pwrite, pwdata, pstrb, prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_sat_counter.sv
// Saturating event counter with synchronous clear; an increment in the clear
// cycle is kept so the event is not lost.
module apb_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= WIDTH'(inc);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB4 protocol checker: infers the phase of every bus cycle, runs eight
// checks, and keeps sticky flags, first-error capture and saturating counters.
module apb_protocol_checker
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_SEL    = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  apb_protocol_checker_if.monitor bus,
  input  logic                   clear,
  output logic [NUM_CHK-1:0]     err_flags,
  output logic                   err_pulse,
  output logic [2:0]             first_code,
  output logic [ADDR_WIDTH-1:0]  first_addr,
  output logic [CNT_WIDTH-1:0]   xfer_cnt,
  output logic [CNT_WIDTH-1:0]   err_cnt
);

  localparam int                    WAIT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(TIMEOUT);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST  = WAIT_WIDTH'(TIMEOUT - 1);
  localparam logic [31:0]           DEPTH      = 32'(MEM_DEPTH);

  apb_state_e            state;
  logic [WAIT_WIDTH-1:0] wait_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [NUM_SEL-1:0]    sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;

  logic               sel_any;
  logic               setup_cyc;
  logic               access_cyc;
  logic               done;
  logic               out_of_range;
  logic               changed;
  logic [NUM_CHK-1:0] fired;

  // The registered state names the previous cycle's phase (a completed ACCESS
  // counts as IDLE), so the current cycle's phase is decided from it here.
  // NOTE: every variable in this block gets a default first so no latch is inferred.
  always_comb begin
    sel_any      = |bus.psel;
    access_cyc   = (state == ACCESS) || ((state == SETUP) && bus.penable);
    setup_cyc    = !access_cyc && sel_any && !bus.penable;
    done         = access_cyc && bus.pready;
    out_of_range = 32'(bus.paddr) >= DEPTH;
    changed      = (bus.paddr != addr_q) || (bus.pwrite != write_q) || (bus.psel != sel_q) ||
                   (write_q && ((bus.pwdata != wdata_q) || (bus.pstrb != strb_q)));

    fired                = '0;
    fired[CHK_SEL_MULTI] = $countones(bus.psel) > 1;
    fired[CHK_NO_ACCESS] = (state == SETUP) && !bus.penable;
    fired[CHK_EN_NO_SEL] = bus.penable && (!sel_any || (state == IDLE));
    fired[CHK_UNSTABLE]  = access_cyc && changed;
    fired[CHK_MISS_ERR]  = done && out_of_range && !bus.pslverr;
    fired[CHK_FALSE_ERR] = done && !out_of_range && bus.pslverr;
    fired[CHK_TIMEOUT]   = access_cyc && !bus.pready && (wait_cnt == WAIT_LAST);
    fired[CHK_READ_STRB] = setup_cyc && !bus.pwrite && (bus.pstrb != '0);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      sel_q    <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
    end else begin
      if (access_cyc) begin
        if (bus.pready) begin
          state <= IDLE;
        end else begin
          state <= ACCESS;
          // Holding at the limit makes the timeout fire once per transfer.
          if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
        end
      end else if (setup_cyc) begin
        state    <= SETUP;
        wait_cnt <= '0;
        addr_q   <= bus.paddr;
        write_q  <= bus.pwrite;
        sel_q    <= bus.psel;
        wdata_q  <= bus.pwdata;
        strb_q   <= bus.pstrb;
      end else begin
        state <= IDLE;
      end
    end
  end

  // A check firing in the clear cycle is recorded as the first post-clear event.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      err_flags  <= '0;
      err_pulse  <= 1'b0;
      first_code <= '0;
      first_addr <= '0;
    end else begin
      err_pulse <= |fired;
      err_flags <= (clear ? '0 : err_flags) | fired;
      if ((|fired) && (clear || (err_flags == '0))) begin
        first_code <= lowest_code(fired);
        first_addr <= bus.paddr;
      end else if (clear) begin
        first_code <= '0;
        first_addr <= '0;
      end
    end
  end

  apb_sat_counter #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
    .pclk   (pclk),
    .preset (preset),
    .inc    (done),
    .clr    (clear),
    .cnt    (xfer_cnt)
  );

  apb_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .pclk   (pclk),
    .preset (preset),
    .inc    (|fired),
    .clr    (clear),
    .cnt    (err_cnt)
  );

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Self-checking bench for apb_protocol_checker: vector table, directed corner
// sequences and randomized transfers against a transfer-level reference model.
module tb_apb_protocol_checker;
  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int SW      = 4;
  localparam int NS      = 4;
  localparam int MD      = 256;
  localparam int TO      = 16;
  localparam int CW      = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          pclk = 1'b0;
  logic          preset;
  logic          clear;
  logic [7:0]    err_flags;
  logic          err_pulse;
  logic [2:0]    first_code;
  logic [AW-1:0] first_addr;
  logic [CW-1:0] xfer_cnt;
  logic [CW-1:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_seen = 0;

  apb_protocol_checker_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .NUM_SEL(NS)) bus ();

  apb_protocol_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .NUM_SEL(NS),
    .MEM_DEPTH(MD), .TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .bus        (bus),
    .clear      (clear),
    .err_flags  (err_flags),
    .err_pulse  (err_pulse),
    .first_code (first_code),
    .first_addr (first_addr),
    .xfer_cnt   (xfer_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [3:0]    strb;
    int            waits;
    logic          slverr;
    logic [7:0]    flags;
    logic [2:0]    code;
    logic [AW-1:0] faddr;
    int            err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus cycle: inputs were set before the edge, outputs are sampled at the next negedge.
  task automatic step();
    @(negedge pclk);
    if (err_pulse) pulse_seen++;
  endtask

  task automatic go_idle(input int n);
    bus.psel = '0; bus.penable = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0; bus.pstrb = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    go_idle(0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    pulse_seen = 0;
  endtask

  task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [3:0] sel,
                         input logic [3:0] strb, input int waits, input logic slverr);
    bus.paddr = addr; bus.pwrite = wr; bus.psel = sel; bus.pwdata = $urandom;
    bus.pstrb = strb; bus.penable = 1'b0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    step();
    bus.penable = 1'b1;
    for (int w = 0; w < waits; w++) step();
    bus.pready = 1'b1; bus.pslverr = slverr;
    step();
  endtask

  task automatic check_all(input string tag, input logic [7:0] flags, input logic [2:0] code,
                           input logic [AW-1:0] faddr, input int xfer, input int err);
    check({tag, " err_flags"}, 32'(err_flags), 32'(flags));
    check({tag, " first_code"}, 32'(first_code), 32'(code));
    check({tag, " first_addr"}, 32'(first_addr), 32'(faddr));
    check({tag, " xfer_cnt"}, 32'(xfer_cnt), 32'(xfer));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(err));
  endtask

  // Transfer-level reference model state.
  logic [7:0]    exp_flags;
  logic [2:0]    exp_code;
  logic [AW-1:0] exp_addr;
  int            exp_xfer;
  int            exp_err;
  int            exp_events;

  task automatic model_reset();
    exp_flags = '0; exp_code = '0; exp_addr = '0; exp_xfer = 0; exp_err = 0; exp_events = 0;
  endtask

  task automatic model_event(input int code, input logic [AW-1:0] addr);
    if (exp_flags == 8'h00) begin
      exp_code = 3'(code);
      exp_addr = addr;
    end
    exp_flags = exp_flags | 8'(1 << code);
    exp_err = (exp_err < CNT_MAX) ? exp_err + 1 : CNT_MAX;
    exp_events++;
  endtask

  initial begin
    preset = 1'b1; clear = 1'b0;
    bus.paddr = '0; bus.psel = '0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.pwdata = '0; bus.pstrb = '0; bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    check_all("reset", 8'h00, 3'd0, '0, 0, 0);
    check("reset err_pulse", 32'(err_pulse), 0);
    preset = 1'b0;
    step();

    // Single-transfer table; each row starts from a cleared checker.
    vecs[0]  = '{9'h010, 1'b1, 4'hF, 2,  1'b0, 8'h00, 3'd0, 9'h000, 0};
    vecs[1]  = '{9'h1FF, 1'b0, 4'h0, 0,  1'b0, 8'h10, 3'd4, 9'h1FF, 1};
    vecs[2]  = '{9'h020, 1'b0, 4'h0, 1,  1'b1, 8'h20, 3'd5, 9'h020, 1};
    vecs[3]  = '{9'h0FF, 1'b1, 4'h3, 0,  1'b0, 8'h00, 3'd0, 9'h000, 0};
    vecs[4]  = '{9'h0FF, 1'b1, 4'h3, 0,  1'b1, 8'h20, 3'd5, 9'h0FF, 1};
    vecs[5]  = '{9'h100, 1'b1, 4'hC, 1,  1'b1, 8'h00, 3'd0, 9'h000, 0};
    vecs[6]  = '{9'h100, 1'b1, 4'hC, 0,  1'b0, 8'h10, 3'd4, 9'h100, 1};
    vecs[7]  = '{9'h030, 1'b0, 4'h3, 0,  1'b0, 8'h80, 3'd7, 9'h030, 1};
    vecs[8]  = '{9'h1FF, 1'b0, 4'h1, 0,  1'b0, 8'h90, 3'd7, 9'h1FF, 2};
    vecs[9]  = '{9'h040, 1'b1, 4'hF, 15, 1'b0, 8'h00, 3'd0, 9'h000, 0};
    vecs[10] = '{9'h040, 1'b1, 4'hF, 16, 1'b0, 8'h40, 3'd6, 9'h040, 1};
    vecs[11] = '{9'h1FF, 1'b0, 4'h0, 16, 1'b0, 8'h50, 3'd6, 9'h1FF, 2};
    for (int i = 0; i < 12; i++) begin
      do_clear();
      do_xfer(vecs[i].addr, vecs[i].wr, 4'(1 << (i % 4)), vecs[i].strb, vecs[i].waits, vecs[i].slverr);
      go_idle(1);
      check_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].code, vecs[i].faddr, 1, vecs[i].err);
    end

    // Address moves during a wait state, then returns before completion.
    do_clear();
    bus.paddr = 9'h010; bus.pwrite = 1'b1; bus.psel = 4'b0001; bus.pwdata = 32'hCAFE_0001;
    bus.pstrb = 4'hF; bus.penable = 1'b0; bus.pready = 1'b0;
    step();
    bus.penable = 1'b1;
    step();
    check("unstable before change", 32'(err_flags), 0);
    bus.paddr = 9'h014;
    step();
    check("unstable flag", 32'(err_flags), 32'h08);
    check("unstable pulse high", 32'(err_pulse), 1);
    bus.paddr = 9'h010; bus.pready = 1'b1;
    step();
    check("unstable pulse low", 32'(err_pulse), 0);
    go_idle(1);
    check_all("unstable", 8'h08, 3'd3, 9'h014, 1, 1);
    check("unstable pulse count", 32'(pulse_seen), 1);

    // Timeout on a legal transfer fires exactly once.
    do_clear();
    do_xfer(9'h010, 1'b1, 4'b0001, 4'hF, 20, 1'b0);
    go_idle(1);
    check_all("timeout once", 8'h40, 3'd6, 9'h010, 1, 1);
    check("timeout pulse count", 32'(pulse_seen), 1);

    // Two selects active with a long wait: code 0 every cycle plus one timeout.
    do_clear();
    bus.paddr = 9'h010; bus.pwrite = 1'b1; bus.psel = 4'b0011; bus.pstrb = 4'hF;
    bus.penable = 1'b0; bus.pready = 1'b0;
    step();
    bus.penable = 1'b1;
    repeat (20) step();
    check_all("multi sel", 8'h41, 3'd0, 9'h010, 0, 21);
    bus.pready = 1'b1;
    step();
    go_idle(1);
    check("multi sel xfer_cnt", 32'(xfer_cnt), 1);
    check("multi sel err_cnt", 32'(err_cnt), 22);

    // SETUP not followed by penable.
    do_clear();
    bus.paddr = 9'h008; bus.pwrite = 1'b0; bus.psel = 4'b0010; bus.pstrb = 4'h0;
    bus.penable = 1'b0; bus.pready = 1'b0;
    step();
    go_idle(1);
    check_all("no access", 8'h02, 3'd1, 9'h008, 0, 1);

    // Back-to-back writes, then a clear colliding with penable-without-select.
    do_clear();
    do_xfer(9'h020, 1'b1, 4'b0100, 4'hF, 0, 1'b0);
    do_xfer(9'h024, 1'b1, 4'b0100, 4'h3, 1, 1'b0);
    do_xfer(9'h028, 1'b1, 4'b0100, 4'hC, 0, 1'b0);
    check_all("back to back", 8'h00, 3'd0, 9'h000, 3, 0);
    clear = 1'b1; bus.psel = '0; bus.penable = 1'b1; bus.pready = 1'b0; bus.paddr = 9'h033;
    step();
    clear = 1'b0;
    go_idle(1);
    check_all("clear vs error", 8'h04, 3'd2, 9'h033, 0, 1);

    // Reset in the middle of a wait state, then a fresh legal read.
    bus.paddr = 9'h050; bus.pwrite = 1'b1; bus.psel = 4'b0001; bus.pstrb = 4'hF;
    bus.penable = 1'b0; bus.pready = 1'b0;
    step();
    bus.penable = 1'b1;
    step();
    step();
    preset = 1'b1;
    #1;
    check_all("in reset", 8'h00, 3'd0, 9'h000, 0, 0);
    go_idle(2);
    preset = 1'b0;
    step();
    check_all("after reset", 8'h00, 3'd0, 9'h000, 0, 0);
    do_xfer(9'h040, 1'b0, 4'b0001, 4'h0, 1, 1'b0);
    go_idle(1);
    check_all("read after reset", 8'h00, 3'd0, 9'h000, 1, 0);

    // Counter saturation.
    do_clear();
    for (int i = 0; i < CNT_MAX + 2; i++) do_xfer(9'h010, 1'b1, 4'b0001, 4'hF, 0, 1'b0);
    go_idle(1);
    check("xfer_cnt saturates", 32'(xfer_cnt), CNT_MAX);
    do_clear();
    bus.psel = '0; bus.penable = 1'b1;
    repeat (CNT_MAX + 4) step();
    go_idle(1);
    check("err_cnt saturates", 32'(err_cnt), CNT_MAX);
    check("err_cnt sat flags", 32'(err_flags), 32'h04);

    // Randomized transfers against the transfer-level model.
    for (int g = 0; g < 6; g++) begin
      do_clear();
      model_reset();
      for (int t = 0; t < 10; t++) begin
        logic [AW-1:0] addr;
        logic          wr;
        logic [3:0]    sel;
        logic [3:0]    strb;
        int            waits;
        logic          miss;
        logic          slverr;
        addr  = AW'($urandom_range(0, (1 << AW) - 1));
        wr    = 1'($urandom_range(0, 1));
        sel   = 4'(1 << $urandom_range(0, NS - 1));
        if (wr) strb = 4'($urandom_range(0, 15));
        else    strb = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        waits  = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
        miss   = (int'(addr) >= MD);
        slverr = miss ^ ($urandom_range(0, 3) == 0);
        do_xfer(addr, wr, sel, strb, waits, slverr);
        // Events occur in bus order: setup, wait states, completion.
        if (!wr && (strb != 4'h0)) model_event(7, addr);
        if (waits >= TO)           model_event(6, addr);
        if (miss && !slverr)       model_event(4, addr);
        else if (!miss && slverr)  model_event(5, addr);
        exp_xfer = (exp_xfer < CNT_MAX) ? exp_xfer + 1 : CNT_MAX;
        check_all($sformatf("rand g%0d t%0d", g, t), exp_flags, exp_code, exp_addr, exp_xfer, exp_err);
        go_idle($urandom_range(0, 2));
      end
      go_idle(1);
      check($sformatf("rand g%0d pulses", g), 32'(pulse_seen), 32'(exp_events));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
